// File: rtl/voting_pkg.sv
// Shared types and helpers for the voting session controller and its arbiter.
package voting_pkg;

  localparam int CAND_W = 3;
  localparam logic [CAND_W-1:0] NO_VOTE = 3'b000;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    OPEN,
    DRAIN,
    RESULT
  } state_e;

  // Codes 1..max_cand are ballots; 0 and anything above max_cand are rejected.
  function automatic logic cand_valid(input logic [CAND_W-1:0] code,
                                      input logic [CAND_W-1:0] max_cand);
    return (code != NO_VOTE) && (code <= max_cand);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts one past the last granted requester.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic         any
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;

  function automatic int wrap(input int p, input int k);
    int s;
    s = p + k;
    return (s >= N) ? s - N : s;
  endfunction

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the loop can leave it unassigned and infer a latch.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    ptr_d = ptr_q;
    for (int k = 0; k < N; k++) begin
      if (!any && req[wrap(int'(ptr_q), k)]) begin
        grant[wrap(int'(ptr_q), k)] = 1'b1;
        any   = 1'b1;
        ptr_d = PW'(wrap(int'(ptr_q), k + 1));
      end
    end
    if (!(advance && any)) ptr_d = ptr_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/voting_session_ctrl.sv
// Voting session sequencer: clear/open/drain/result phases, booth arbitration,
// ballot validation and winner latch for the downstream tally.
module voting_session_ctrl
  import voting_pkg::*;
#(
  parameter int                NUM_BOOTHS     = 4,
  parameter logic [CAND_W-1:0] MAX_CAND       = 3'd5,
  parameter int                SESSION_CYCLES = 1000,
  parameter int                TALLY_LAT      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic [NUM_BOOTHS-1:0]        booth_req,
  input  logic [CAND_W*NUM_BOOTHS-1:0] booth_cand,
  output logic [NUM_BOOTHS-1:0]        booth_ack,
  output logic [NUM_BOOTHS-1:0]        booth_nak,
  output logic                         vote_valid,
  output logic [CAND_W-1:0]            vote_cand,
  output logic                         tally_rst,
  input  logic [CAND_W-1:0]            winner_in,
  output logic                         result_valid,
  output logic [CAND_W-1:0]            result,
  output logic [15:0]                  votes_cast,
  output logic                         busy
);

  localparam int TW = $clog2(SESSION_CYCLES) + 1;
  localparam int DW = $clog2(TALLY_LAT) + 1;

  state_e                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [DW-1:0]           drain_q, drain_d;
  logic [NUM_BOOTHS-1:0]   mask_q;
  logic [NUM_BOOTHS-1:0]   ack_q, ack_d, nak_q, nak_d;
  logic                    vv_q, vv_d;
  logic [CAND_W-1:0]       vc_q, vc_d;
  logic [15:0]             votes_q, votes_d;
  logic [CAND_W-1:0]       result_q, result_d;

  logic                    arb_en;
  logic [NUM_BOOTHS-1:0]   grant;
  logic                    any_grant;
  logic [CAND_W-1:0]       gnt_cand;
  logic                    gnt_ok;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = OPEN;
      OPEN:    if (stop || timer_q == '0) state_d = DRAIN;
      DRAIN:   if (drain_q == '0) state_d = RESULT;
      RESULT:  if (start) state_d = CLEAR;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Arbitration stops on the closing cycle so nothing is granted after the window.
  always_comb begin
    arb_en       = (state_q == OPEN) && !stop && (timer_q != '0);
    busy         = (state_q == CLEAR) || (state_q == OPEN) || (state_q == DRAIN);
    result_valid = (state_q == RESULT);
    tally_rst    = rst || (state_q == CLEAR);
  end

  rr_arbiter #(.N(NUM_BOOTHS)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (booth_req & ~mask_q & {NUM_BOOTHS{arb_en}}),
    .advance (arb_en),
    .grant   (grant),
    .any     (any_grant)
  );

  always_comb begin
    gnt_cand = NO_VOTE;
    for (int i = 0; i < NUM_BOOTHS; i++) begin
      if (grant[i]) gnt_cand = booth_cand[i*CAND_W +: CAND_W];
    end
    gnt_ok = any_grant && cand_valid(gnt_cand, MAX_CAND);
  end

  always_comb begin
    ack_d   = gnt_ok ? grant : '0;
    nak_d   = (any_grant && !gnt_ok) ? grant : '0;
    vv_d    = gnt_ok;
    vc_d    = gnt_ok ? gnt_cand : NO_VOTE;

    votes_d = votes_q;
    if (state_d == CLEAR)            votes_d = '0;
    else if (vv_d && votes_q != '1)  votes_d = votes_q + 16'd1;

    timer_d = timer_q;
    if (state_q == CLEAR)                      timer_d = TW'(SESSION_CYCLES - 1);
    else if (state_q == OPEN && timer_q != '0) timer_d = timer_q - TW'(1);

    drain_d = drain_q;
    if (state_q == OPEN && state_d == DRAIN)       drain_d = DW'(TALLY_LAT - 1);
    else if (state_q == DRAIN && drain_q != '0)    drain_d = drain_q - DW'(1);

    result_d = result_q;
    if (state_q == DRAIN && drain_q == '0) result_d = winner_in;
  end

  // NOTE: every register here, the mask and timers included, is reset so a
  // mid-session abort leaves no stale grant, count or timer behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q  <= '0;
      drain_q  <= '0;
      mask_q   <= '0;
      ack_q    <= '0;
      nak_q    <= '0;
      vv_q     <= 1'b0;
      vc_q     <= NO_VOTE;
      votes_q  <= '0;
      result_q <= NO_VOTE;
    end else begin
      timer_q  <= timer_d;
      drain_q  <= drain_d;
      mask_q   <= grant;
      ack_q    <= ack_d;
      nak_q    <= nak_d;
      vv_q     <= vv_d;
      vc_q     <= vc_d;
      votes_q  <= votes_d;
      result_q <= result_d;
    end
  end

  assign booth_ack  = ack_q;
  assign booth_nak  = nak_q;
  assign vote_valid = vv_q;
  assign vote_cand  = vc_q;
  assign votes_cast = votes_q;
  assign result     = result_q;

endmodule

// File: tb/tb_voting_session_ctrl.sv
// Directed bench for voting_session_ctrl with a behavioural tally supplying winner_in.
module tb_voting_session_ctrl;

  localparam int N  = 4;
  localparam int SC = 8;
  localparam int TL = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [N-1:0]  booth_req = '0;
  logic [3*N-1:0] booth_cand = '0;
  logic [N-1:0]  booth_ack, booth_nak;
  logic          vote_valid;
  logic [2:0]    vote_cand;
  logic          tally_rst;
  logic [2:0]    winner_in;
  logic          result_valid;
  logic [2:0]    result;
  logic [15:0]   votes_cast;
  logic          busy;

  int checks = 0;
  int errors = 0;

  voting_session_ctrl #(
    .NUM_BOOTHS(N), .MAX_CAND(3'd5), .SESSION_CYCLES(SC), .TALLY_LAT(TL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .booth_req(booth_req), .booth_cand(booth_cand),
    .booth_ack(booth_ack), .booth_nak(booth_nak),
    .vote_valid(vote_valid), .vote_cand(vote_cand), .tally_rst(tally_rst),
    .winner_in(winner_in), .result_valid(result_valid), .result(result),
    .votes_cast(votes_cast), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural tally: per-code counters, winner = highest count, lowest code on ties.
  int cnt [8];
  int best;
  always @(posedge clk) begin
    if (tally_rst) begin
      for (int c = 0; c < 8; c++) cnt[c] <= 0;
    end else if (vote_valid) begin
      cnt[vote_cand] <= cnt[vote_cand] + 1;
    end
  end
  always_comb begin
    winner_in = 3'd0;
    best      = 0;
    for (int c = 1; c < 8; c++) begin
      if (cnt[c] > best) begin
        best      = cnt[c];
        winner_in = 3'(c);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++; if (tally_rst !== 1'b1) begin errors++; $display("FAIL rst_tally_rst: got %b want 1", tally_rst); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (result_valid !== 1'b0 || result !== 3'b000) begin errors++; $display("FAIL rst_result: got %b/%b want 0/000", result_valid, result); end
    checks++; if (votes_cast !== 16'd0 || vote_valid !== 1'b0) begin errors++; $display("FAIL rst_votes: got %0d/%b want 0/0", votes_cast, vote_valid); end
    rst = 1'b0;
  endtask

  task automatic test_single_vote();
    booth_req = 4'b0010;
    booth_cand[5:3] = 3'b010;
    tick();
    checks++; if (booth_ack !== 4'b0000) begin errors++; $display("FAIL idle_pending: got %b want 0000", booth_ack); end
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (tally_rst !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL clear_phase: got tally_rst=%b busy=%b want 1/1", tally_rst, busy); end
    tick();
    checks++; if (booth_ack !== 4'b0000 || tally_rst !== 1'b0) begin errors++; $display("FAIL open_first: got ack=%b tally_rst=%b want 0000/0", booth_ack, tally_rst); end
    tick();
    checks++; if (booth_ack !== 4'b0010 || vote_valid !== 1'b1 || vote_cand !== 3'b010) begin errors++; $display("FAIL single_ack: got %b/%b/%b want 0010/1/010", booth_ack, vote_valid, vote_cand); end
    checks++; if (votes_cast !== 16'd1) begin errors++; $display("FAIL single_count: got %0d want 1", votes_cast); end
    booth_req = '0;
    stop = 1'b1; tick(); stop = 1'b0;
    checks++; if (booth_ack !== 4'b0000 || vote_valid !== 1'b0 || vote_cand !== 3'b000) begin errors++; $display("FAIL single_idle_out: got %b/%b/%b want 0000/0/000", booth_ack, vote_valid, vote_cand); end
    tick(); tick();
    checks++; if (result_valid !== 1'b1 || result !== 3'b010 || busy !== 1'b0) begin errors++; $display("FAIL single_result: got %b/%b/%b want 1/010/0", result_valid, result, busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ack;
    logic [2:0] exp_cand [4];
    exp_cand[0] = 3'd1; exp_cand[1] = 3'd2; exp_cand[2] = 3'd1; exp_cand[3] = 3'd3;
    rst = 1'b1; tick(); rst = 1'b0;
    booth_req  = 4'b1111;
    booth_cand = {3'd3, 3'd1, 3'd2, 3'd1};
    start = 1'b1; tick(); start = 1'b0;
    tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_ack = 4'b0001 << (k % 4);
      checks++;
      if (booth_ack !== exp_ack || vote_cand !== exp_cand[k % 4]) begin
        errors++; $display("FAIL rr_grant%0d: got %b/%b want %b/%b", k, booth_ack, vote_cand, exp_ack, exp_cand[k % 4]);
      end
    end
    checks++; if (votes_cast !== 16'd6) begin errors++; $display("FAIL rr_count: got %0d want 6", votes_cast); end
    stop = 1'b1; booth_req = '0; tick(); stop = 1'b0;
    checks++; if (booth_ack !== 4'b0000 || votes_cast !== 16'd6) begin errors++; $display("FAIL rr_stop_cycle: got %b/%0d want 0000/6", booth_ack, votes_cast); end
    tick(); tick();
    checks++; if (result_valid !== 1'b1 || result !== 3'b001) begin errors++; $display("FAIL rr_result: got %b/%b want 1/001", result_valid, result); end
  endtask

  task automatic test_invalid_and_expiry();
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (votes_cast !== 16'd0 || result_valid !== 1'b0) begin errors++; $display("FAIL inv_clear: got %0d/%b want 0/0", votes_cast, result_valid); end
    tick();
    booth_req = 4'b0100; booth_cand[8:6] = 3'b000;
    tick();
    checks++; if (booth_nak !== 4'b0100 || booth_ack !== 4'b0000 || vote_valid !== 1'b0) begin errors++; $display("FAIL nak_zero: got nak=%b ack=%b vv=%b want 0100/0000/0", booth_nak, booth_ack, vote_valid); end
    booth_cand[8:6] = 3'b111;
    tick();
    checks++; if (booth_nak !== 4'b0000) begin errors++; $display("FAIL nak_mask: got %b want 0000", booth_nak); end
    tick();
    checks++; if (booth_nak !== 4'b0100 || vote_valid !== 1'b0 || votes_cast !== 16'd0) begin errors++; $display("FAIL nak_seven: got %b/%b/%0d want 0100/0/0", booth_nak, vote_valid, votes_cast); end
    booth_req = '0;
    tick(); tick(); tick(); tick();
    // Last open cycle: stop coincides with timer expiry, with a fresh request.
    stop = 1'b1; booth_req = 4'b0001; booth_cand[2:0] = 3'd1;
    tick(); stop = 1'b0;
    checks++; if (booth_ack !== 4'b0000 || busy !== 1'b1 || result_valid !== 1'b0) begin errors++; $display("FAIL exp_drain1: got ack=%b busy=%b rv=%b want 0000/1/0", booth_ack, busy, result_valid); end
    tick();
    checks++; if (result_valid !== 1'b0 || booth_ack !== 4'b0000) begin errors++; $display("FAIL exp_drain2: got rv=%b ack=%b want 0/0000", result_valid, booth_ack); end
    tick();
    checks++; if (result_valid !== 1'b1 || result !== 3'b000 || booth_ack !== 4'b0000) begin errors++; $display("FAIL exp_result: got %b/%b/%b want 1/000/0000", result_valid, result, booth_ack); end
    booth_req = '0;
  endtask

  task automatic test_reset_mid_session();
    start = 1'b1; tick(); start = 1'b0;
    booth_req = 4'b0011; booth_cand[2:0] = 3'd1; booth_cand[5:3] = 3'd2;
    tick();
    for (int k = 0; k < 5; k++) tick();
    checks++; if (votes_cast !== 16'd5) begin errors++; $display("FAIL mid_count: got %0d want 5", votes_cast); end
    rst = 1'b1; tick();
    checks++; if (busy !== 1'b0 || votes_cast !== 16'd0 || tally_rst !== 1'b1 || result_valid !== 1'b0) begin errors++; $display("FAIL mid_rst: got busy=%b votes=%0d trst=%b rv=%b want 0/0/1/0", busy, votes_cast, tally_rst, result_valid); end
    checks++; if (booth_ack !== 4'b0000) begin errors++; $display("FAIL mid_rst_ack: got %b want 0000", booth_ack); end
    rst = 1'b0; tick();
    checks++; if (booth_ack !== 4'b0000 || tally_rst !== 1'b0) begin errors++; $display("FAIL mid_idle: got ack=%b trst=%b want 0000/0", booth_ack, tally_rst); end
    booth_req = '0;
  endtask

  task automatic test_back_to_back();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    start = 1'b1; booth_req = 4'b1000; booth_cand[11:9] = 3'b100;
    tick(); start = 1'b0;
    checks++; if (busy !== 1'b1 || tally_rst !== 1'b0) begin errors++; $display("FAIL start_in_open: got busy=%b trst=%b want 1/0", busy, tally_rst); end
    checks++; if (booth_ack !== 4'b1000 || votes_cast !== 16'd1) begin errors++; $display("FAIL b2b_vote: got %b/%0d want 1000/1", booth_ack, votes_cast); end
    booth_req = '0; stop = 1'b1; tick(); stop = 1'b0;
    tick(); tick();
    checks++; if (result_valid !== 1'b1 || result !== 3'b100) begin errors++; $display("FAIL b2b_result: got %b/%b want 1/100", result_valid, result); end
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (tally_rst !== 1'b1 || votes_cast !== 16'd0 || result_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: got trst=%b votes=%0d rv=%b busy=%b want 1/0/0/1", tally_rst, votes_cast, result_valid, busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tick();
    test_reset();
    test_single_vote();
    test_round_robin();
    test_invalid_and_expiry();
    test_reset_mid_session();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/voting_session_ctrl.md
# voting_session_ctrl

Session controller and booth arbiter for the `voting_machine` tally. It sequences a voting session through clear, open, drain and result phases. During the open phase it shares the single tally input among `NUM_BOOTHS` booths using round-robin arbitration, forwards at most one ballot per cycle, rejects invalid candidate codes, and latches the tally's winner when the session closes.

## Interface
- `NUM_BOOTHS`, 4: number of requesting booths, 2..8.
- `MAX_CAND`, 3'd5: highest valid candidate code; valid codes are 1..`MAX_CAND`.
- `SESSION_CYCLES`, 1000: length of the open phase in clk cycles, ≥ 1.
- `TALLY_LAT`, 2: cycles to wait after the last forwarded vote before sampling `winner_in`, ≥ 1.
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; opens a session from IDLE or RESULT.
- `stop`  in  1  one-cycle pulse; closes the open phase early.
- `booth_req`  in  NUM_BOOTHS  per-booth ballot request; level, held until ack or nak.
- `booth_cand`  in  3*NUM_BOOTHS  per-booth candidate code; booth i uses bits [3i+2:3i]; stable while req is high.
- `booth_ack`  out  NUM_BOOTHS  one-hot, one-cycle pulse: ballot accepted.
- `booth_nak`  out  NUM_BOOTHS  one-hot, one-cycle pulse: ballot rejected (invalid code).
- `vote_valid`  out  1  tally strobe.
- `vote_cand`  out  3  candidate code to tally; 3'b000 when `vote_valid`=0.
- `tally_rst`  out  1  reset to tally.
- `winner_in`  in  3  winner from tally.
- `result_valid`  out  1  high in RESULT.
- `result`  out  3  latched winner.
- `votes_cast`  out  16  accepted ballots in this session; saturates at 16'hFFFF.
- `busy`  out  1  high in CLEAR, OPEN and DRAIN.

## Operation
- States: IDLE, CLEAR, OPEN, DRAIN, RESULT.
- IDLE → CLEAR on `start`.
- CLEAR lasts 1 cycle: `tally_rst`=1, `votes_cast` cleared, session timer loaded with `SESSION_CYCLES`-1, then → OPEN.
- OPEN: the timer decrements each cycle. On `stop`, or when the timer is 0, → DRAIN; the two events together cause one transition.
- DRAIN: a counter loads `TALLY_LAT`-1 and counts down. At 0, `result` ← `winner_in` and → RESULT.
- RESULT: holds `result` and `result_valid`. `start` → CLEAR, which begins a new session.
- `start` in CLEAR, OPEN or DRAIN is ignored. `stop` outside OPEN is ignored.
- Arbitration applies in OPEN only, and not in the cycle `stop` or timer expiry is seen.
  - The eligible set is `booth_req` & ~`mask`.
  - Round-robin starts one past the last granted booth; the pointer resets to booth 0.
  - One grant per cycle, and the pointer advances only on a grant (ack or nak).
- Grant with a valid code (1..`MAX_CAND`): `booth_ack`, `vote_valid`=1, `vote_cand`=code, `votes_cast`+1.
- Grant with an invalid code (0, or >`MAX_CAND`): `booth_nak` only. No tally strobe and no count.
- `mask` bit i is set for the cycle after booth i is acked or nakked. This absorbs the booth's deassert latency and prevents double-counting.
- Requests in states other than OPEN are neither acked nor nakked and stay pending.
- `tally_rst` = `rst` | (state==CLEAR).

## Timing
- Reset values:
  - State = IDLE.
  - All outputs = 0, except `tally_rst`=1 while `rst` is high.
  - `result`=3'b000, `votes_cast`=0, RR pointer=0, `mask`=0.
- Reset mid-session aborts immediately: no result is latched and the tally is cleared.
- Ballot latency: `booth_req` sampled high at edge t gives `booth_ack`/`booth_nak`, `vote_valid` and `vote_cand` all registered and high during cycle t+1.
- `start` at edge t: CLEAR during t+1, OPEN from t+2. The open phase lasts exactly `SESSION_CYCLES` cycles unless stopped.
- A grant issued on the last OPEN cycle is still forwarded in the next cycle and counted. DRAIN covers it.
- `result_valid` rises `TALLY_LAT` cycles after OPEN exits.
- Throughput: 1 ballot/cycle when at least 2 booths request. A single booth gets at most 1 ballot per 2 cycles because of the mask.

## Structure
- The shared package `voting_pkg` holds:
  - the state enum (IDLE, CLEAR, OPEN, DRAIN, RESULT);
  - `CAND_W`=3;
  - the `NO_VOTE`=3'b000 constant;
  - the `cand_valid()` function.
- Sub-module `rr_arbiter`: parameter N; inputs `req` and `advance`; outputs one-hot `grant` and `any`; owns the pointer.
- The top level holds the FSM, timers, mask, counter and output registers.

## Test plan
- Reset, `start`, booth 1 votes 3'b010 → ack in the cycle after sampling, `vote_cand`=010, `votes_cast`=1, and tally cleared during CLEAR.
- Booths 0–3 all request continuously with codes 1, 2, 1, 3 → grants in order 0, 1, 2, 3, 0…, one per cycle, no double count; after `stop`, `result`=3'b001 once the tally agrees.
- Booth 2 sends 3'b000, then 3'b111 → two `booth_nak` pulses, `vote_valid` stays 0, `votes_cast` unchanged.
- `SESSION_CYCLES`=8 with `stop` asserted on the expiry cycle → a single DRAIN, then `result_valid` exactly `TALLY_LAT` cycles later; a request on that cycle gets no ack.
- `rst` pulsed in OPEN after 5 votes → next cycle: IDLE, `votes_cast`=0, `tally_rst`=1, `result_valid`=0, pending request unacked.
- `start` during OPEN ignored; `start` in RESULT → new CLEAR, `votes_cast` back to 0.
